// File: rtl/update_sequencer.sv
// Upstream feeder for the arbitrage container: queues edge-weight updates in a FIFO
// and launches them one at a time, handshaking with container_reset/container_done.
module update_sequencer #(
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned WT_W    = 32,
  parameter int unsigned NODES   = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 2**20
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  input  logic [IDX_W-1:0]         wr_src,
  input  logic [IDX_W-1:0]         wr_dst,
  input  logic [WT_W-1:0]          wr_e,
  output logic                     wr_ready,
  input  logic [IDX_W-1:0]         src_cfg,
  input  logic                     err_clr,
  input  logic                     container_done,
  output logic                     container_reset,
  output logic [IDX_W-1:0]         u_src,
  output logic [IDX_W-1:0]         u_dst,
  output logic [WT_W-1:0]          u_e,
  output logic [IDX_W-1:0]         src,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              run_cnt,
  output logic                     bad_upd,
  output logic                     timeout_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 * IDX_W + WT_W;
  localparam int unsigned WD_W  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RETIRE} state_e;

  state_e               state_q;
  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WD_W-1:0]      wd_q;
  logic                 cr_q, busy_q, bad_q, tmo_q;
  logic [IDX_W-1:0]     u_src_q, u_dst_q, src_q;
  logic [WT_W-1:0]      u_e_q;
  logic [15:0]          run_cnt_q;

  logic upd_bad, push, pop, done_seen, tmo_hit;

  // Write acceptance and FIFO occupancy bookkeeping
  always_comb begin
    upd_bad   = (wr_src == wr_dst) || (32'(wr_src) >= NODES) || (32'(wr_dst) >= NODES);
    push      = wr_valid && wr_ready && !upd_bad;
    pop       = (state_q == S_LAUNCH);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    // done still high in the pulse cycle is left over from the previous run
    done_seen = (state_q == S_WAIT) && container_done && !cr_q;
    tmo_hit   = (state_q == S_WAIT) && !done_seen && (wd_q == WD_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_src, wr_dst, wr_e};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bad_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      bad_q   <= (wr_valid && wr_ready && upd_bad) || (bad_q && !err_clr);
      tmo_q   <= tmo_hit || (tmo_q && !err_clr);
    end
  end

  // Run sequencing: IDLE -> LAUNCH -> WAIT -> RETIRE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cr_q      <= 1'b0;
      busy_q    <= 1'b0;
      wd_q      <= '0;
      u_src_q   <= '0;
      u_dst_q   <= '0;
      u_e_q     <= '0;
      src_q     <= '0;
      run_cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (count_q != '0) state_q <= S_LAUNCH;
        end
        S_LAUNCH: begin
          {u_src_q, u_dst_q, u_e_q} <= mem_q[rd_ptr_q];
          src_q   <= src_cfg;
          cr_q    <= 1'b1;
          busy_q  <= 1'b1;
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cr_q <= 1'b0;
          wd_q <= wd_q + WD_W'(1);
          if (done_seen || tmo_hit) state_q <= S_RETIRE;
        end
        S_RETIRE: begin
          run_cnt_q <= run_cnt_q + 16'd1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_ready        = (count_q != CNT_W'(DEPTH));
  assign fifo_count      = count_q;
  assign container_reset = cr_q;
  assign u_src           = u_src_q;
  assign u_dst           = u_dst_q;
  assign u_e             = u_e_q;
  assign src             = src_q;
  assign busy            = busy_q;
  assign run_cnt         = run_cnt_q;
  assign bad_upd         = bad_q;
  assign timeout_err     = tmo_q;

endmodule

// File: tb/tb_update_sequencer.sv
// Randomised bench for update_sequencer: a queue-based FIFO model plus a small
// container responder, with directed latency, overflow, invalid, timeout and reset cases.
module tb_update_sequencer;

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned WT_W    = 32;
  localparam int unsigned NODES   = 20;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 64;

  typedef struct packed {
    logic [IDX_W-1:0] s;
    logic [IDX_W-1:0] d;
    logic [WT_W-1:0]  e;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  logic wr_valid, err_clr, container_done;
  logic [IDX_W-1:0] wr_src, wr_dst, src_cfg;
  logic [WT_W-1:0]  wr_e;
  logic wr_ready, container_reset, busy, bad_upd, timeout_err;
  logic [IDX_W-1:0] u_src, u_dst, src;
  logic [WT_W-1:0]  u_e;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0] run_cnt;

  update_sequencer #(.IDX_W(IDX_W), .WT_W(WT_W), .NODES(NODES), .DEPTH(DEPTH),
                     .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_src(wr_src),
    .wr_dst(wr_dst), .wr_e(wr_e), .wr_ready(wr_ready), .src_cfg(src_cfg),
    .err_clr(err_clr), .container_done(container_done),
    .container_reset(container_reset), .u_src(u_src), .u_dst(u_dst), .u_e(u_e),
    .src(src), .busy(busy), .fifo_count(fifo_count), .run_cnt(run_cnt),
    .bad_upd(bad_upd), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  ent_t q[$];
  ent_t last_u;
  logic [IDX_W-1:0] last_src;
  logic exp_bad;
  int   exp_runs;
  bit   auto_resp;
  int   delay;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock: apply the spec rules to the model for this edge, then compare
  task automatic step();
    logic acc, inval, clr, pb, pcr;
    logic [IDX_W-1:0] sc;
    ent_t w, h;
    w     = '{s: wr_src, d: wr_dst, e: wr_e};
    acc   = wr_valid && wr_ready;
    inval = (w.s == w.d) || (int'(w.s) >= NODES) || (int'(w.d) >= NODES);
    clr = err_clr; sc = src_cfg; pb = busy; pcr = container_reset;
    @(posedge clk); #1;
    if (acc && !inval) q.push_back(w);
    if (acc && inval) exp_bad = 1'b1;
    else if (clr) exp_bad = 1'b0;
    if (auto_resp && delay > 0) begin
      delay--;
      if (delay == 0) container_done = 1'b1;
    end
    if (container_reset) begin
      chk("pulse_width", pcr, 0);
      chk("pop_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        h = q.pop_front();
        last_u = h; last_src = sc; exp_runs++;
      end
      chk("busy_launch", busy, 1);
      if (auto_resp) begin
        container_done = 1'b0;
        delay = $urandom_range(1, 20);
      end
    end
    chk("u_src", u_src, last_u.s);
    chk("u_dst", u_dst, last_u.d);
    chk("u_e", u_e, last_u.e);
    chk("src", src, last_src);
    chk("fifo_count", fifo_count, q.size());
    chk("wr_ready", wr_ready, q.size() != DEPTH);
    chk("bad_upd", bad_upd, exp_bad);
    if (pb && !busy && reset_n) chk("run_cnt_retire", run_cnt, 16'(exp_runs));
  endtask

  task automatic put(input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] d,
                     input logic [WT_W-1:0] e);
    wr_valid = 1'b1; wr_src = s; wr_dst = d; wr_e = e;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    do begin step(); n++; end while (!container_reset && n < budget);
    chk("pulse_seen", container_reset, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin step(); n++; end while ((busy || fifo_count != 0) && n < budget);
    chk("idle_reached", busy || fifo_count != 0, 0);
  endtask

  task automatic rand_valid(output ent_t w);
    w.s = IDX_W'($urandom_range(0, NODES - 1));
    w.d = IDX_W'((int'(w.s) + 1 + $urandom_range(0, NODES - 2)) % NODES);
    w.e = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    ent_t w;
    reset_n = 1'b0; wr_valid = 1'b0; wr_src = '0; wr_dst = '0; wr_e = '0;
    src_cfg = '0; err_clr = 1'b0; container_done = 1'b0;
    q.delete(); last_u = '0; last_src = '0; exp_bad = 1'b0; exp_runs = 0;
    auto_resp = 1'b0; delay = 0;

    repeat (3) step();
    chk("rst_container_reset", container_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_run_cnt", run_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset_n = 1'b1;
    step();

    // single update, done 50 cycles after the pulse
    src_cfg = 5'd9;
    put(5'd3, 5'd7, 32'd100);
    wait_pulse(10, n);
    chk("launch_latency", n, 2);
    chk("t1_u_src", u_src, 3);
    chk("t1_u_dst", u_dst, 7);
    chk("t1_u_e", u_e, 100);
    chk("t1_src", src, 9);
    repeat (50) step();
    chk("t1_busy_held", busy, 1);
    container_done = 1'b1;
    n = 0;
    do begin step(); n++; end while (busy && n < 10);
    chk("busy_fall_latency", n, 2);
    chk("t1_run_cnt", run_cnt, 1);
    container_done = 1'b0;

    // burst of DEPTH+1 writes while the container is stalled
    put(5'd1, 5'd2, 32'hFFFF_FFFB);
    wait_pulse(10, n);
    wr_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == DEPTH) begin
        chk("burst_full_count", fifo_count, DEPTH);
        chk("burst_full_ready", wr_ready, 0);
      end
      rand_valid(w);
      wr_src = w.s; wr_dst = w.d; wr_e = w.e;
      step();
    end
    wr_valid = 1'b0;
    chk("burst_count_after", fifo_count, DEPTH);
    auto_resp = 1'b1;
    container_done = 1'b1;
    wait_idle(3000);
    chk("burst_run_cnt", run_cnt, 18);

    // invalid updates are dropped and flagged; set beats clear
    put(5'd4, 5'd4, 32'd5);
    put(5'd25, 5'd1, 32'd5);
    chk("inval_count", fifo_count, 0);
    chk("inval_bad", bad_upd, 1);
    err_clr = 1'b1;
    put(5'd2, 5'd22, 32'd5);
    chk("set_beats_clear", bad_upd, 1);
    step();
    err_clr = 1'b0;
    chk("err_clr_bad", bad_upd, 0);

    // watchdog: done never arrives
    auto_resp = 1'b0;
    container_done = 1'b0;
    put(5'd10, 5'd11, 32'd77);
    put(5'd12, 5'd13, 32'd88);
    wait_pulse(10, n);
    chk("tmo_before", timeout_err, 0);
    n = 0;
    do begin step(); n++; end while (!timeout_err && n < 200);
    chk("tmo_latency", n, TIMEOUT);
    wait_pulse(10, n);
    chk("tmo_next_latency", n, 3);
    chk("tmo_run_cnt", run_cnt, 19);
    chk("tmo_next_u_src", u_src, 12);
    container_done = 1'b1;
    wait_idle(100);
    chk("tmo_run_cnt2", run_cnt, 20);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr_tmo", timeout_err, 0);

    // stale done from the previous run must not retire the new one
    container_done = 1'b1;
    put(5'd5, 5'd6, 32'd7);
    wait_pulse(10, n);
    container_done = 1'b0;
    repeat (10) step();
    chk("stale_busy", busy, 1);
    chk("stale_run_cnt", run_cnt, 20);
    container_done = 1'b1;
    wait_idle(100);
    chk("stale_run_cnt2", run_cnt, 21);

    // random traffic with a randomly delayed container
    auto_resp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_src   = IDX_W'($urandom_range(0, 23));
      wr_dst   = IDX_W'($urandom_range(0, 23));
      wr_e     = $urandom;
      src_cfg  = IDX_W'($urandom);
      err_clr  = ($urandom_range(0, 15) == 0);
      step();
    end
    wr_valid = 1'b0; err_clr = 1'b0;
    wait_idle(5000);
    chk("rand_run_cnt", run_cnt, 16'(exp_runs));
    chk("rand_no_tmo", timeout_err, 0);

    // reset during WAIT with three queued
    auto_resp = 1'b0;
    container_done = 1'b0;
    put(5'd1, 5'd3, 32'd11);
    wait_pulse(10, n);
    put(5'd2, 5'd4, 32'd12);
    put(5'd5, 5'd8, 32'd13);
    put(5'd6, 5'd9, 32'd14);
    step();
    chk("pre_rst_count", fifo_count, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_u_src", u_src, 0);
    chk("mid_rst_u_e", u_e, 0);
    chk("mid_rst_run_cnt", run_cnt, 0);
    chk("mid_rst_ready", wr_ready, 1);
    q.delete(); last_u = '0; last_src = '0; exp_bad = 1'b0; exp_runs = 0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (10) step();
    chk("post_rst_run_cnt", run_cnt, 0);
    chk("post_rst_no_pulse", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
